uart_apb_sequencer: RTL and testbench



---
 rtl/uart_apb_seq_pkg.sv | 25 ++
 rtl/uart_apb_seq_master.sv | 57 +++++
 rtl/uart_apb_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_seq_pkg.sv
// Shared definitions for the UART APB sequencer.
// Provides the sequencer state encoding, default register addresses and
// the data/count widths used by the top level and the APB transfer engine.
package uart_apb_seq_pkg;

  localparam int unsigned APB_DW   = 32;
  localparam int unsigned RX_CNT_W = 5;

  localparam logic [APB_DW-1:0] TXD_ADDR_DEF  = 32'h0000_0000;
  localparam logic [APB_DW-1:0] RXD_ADDR_DEF  = 32'h0000_0004;
  localparam logic [APB_DW-1:0] STAT_ADDR_DEF = 32'h0000_0008;

  // *_S = APB SETUP cycle on the bus, *_A = APB ACCESS cycle on the bus.
  typedef enum logic [2:0] {
    IDLE,
    ST_S,
    ST_A,
    RD_S,
    RD_A,
    PUSH,
    TX_S,
    TX_A
  } seq_state_t;

endpackage

// File: rtl/uart_apb_seq_master.sv
// Two-phase APB transfer engine (no pready: SETUP then ACCESS, always).
// Ports:
//   clk, rst_          clock, asynchronous active-low reset
//   req                start a transfer; SETUP is driven in the next cycle
//   addr, wr, wdata    transfer attributes, captured together with req
//   prdata             APB read data from the slave
//   done               high during the ACCESS cycle
//   rdata              read data, valid when done is high
//   paddr, pwdata, psel, penable, pwrite   registered APB master outputs
// req is only raised while the engine is idle or in ACCESS, so a new SETUP
// can follow an ACCESS back to back. paddr/pwdata hold between transfers.
module uart_apb_seq_master
  import uart_apb_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic              req,
  input  logic [APB_DW-1:0] addr,
  input  logic              wr,
  input  logic [APB_DW-1:0] wdata,
  input  logic [APB_DW-1:0] prdata,
  output logic              done,
  output logic [APB_DW-1:0] rdata,
  output logic [APB_DW-1:0] paddr,
  output logic [APB_DW-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      paddr   <= '0;
      pwdata  <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
    end else if (req) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      paddr   <= addr;
      pwrite  <= wr;
      if (wr) begin
        pwdata <= wdata;
      end
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

  assign done  = psel & penable;
  assign rdata = prdata;

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master servicing the UART top-level APB slave.
// Reads the status word, drains the RX FIFO one byte per RXD read into a
// valid/ready output stream, and writes bytes from a valid/ready input
// stream to the TX data register while the TX FIFO is not full.
// Ports:
//   clk, rst_            clock, asynchronous active-low reset
//   uart_int_i           UART interrupt (level, active high)
//   prdata_i             APB read data
//   paddr_o, pwdata_o, psel_o, penable_o, pwrite_o   APB master bus
//   rx_data_o, rx_valid_o, rx_ready_i                received byte stream
//   tx_data_i, tx_valid_i, tx_ready_o                byte stream to send
//   busy_o               sequencer not idle
// Optional: define UART_APB_SEQ_POLL_EN to start a status read every
// POLL_CYCLES idle cycles even without an interrupt.
module uart_apb_sequencer
  import uart_apb_seq_pkg::*;
#(
  parameter logic [APB_DW-1:0] TXD_ADDR    = TXD_ADDR_DEF,
  parameter logic [APB_DW-1:0] RXD_ADDR    = RXD_ADDR_DEF,
  parameter logic [APB_DW-1:0] STAT_ADDR   = STAT_ADDR_DEF,
  parameter int unsigned       RXCNT_LSB   = 0,
  parameter int unsigned       TXFULL_BIT  = 8,
  parameter int unsigned       POLL_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              uart_int_i,
  input  logic [APB_DW-1:0] prdata_i,
  output logic [APB_DW-1:0] paddr_o,
  output logic [APB_DW-1:0] pwdata_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [7:0]        tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              busy_o
);

  seq_state_t          state;
  logic [RX_CNT_W-1:0] rx_remain;
  logic                tx_full_q;
  logic [7:0]          rx_data_q;
  logic                rx_valid_q;
  logic                tx_ready_q;

  logic                go_st;
  logic                go_rd;
  logic                go_tx;
  logic                req;
  logic [APB_DW-1:0]   req_addr;
  logic [APB_DW-1:0]   req_wdata;
  logic                done;
  logic [APB_DW-1:0]   rdata;
  logic [RX_CNT_W-1:0] stat_cnt;
  logic                poll_hit;

  // Bits of the data/status word that this block does not interpret.
  logic                unused_rdata;
  assign unused_rdata = ^rdata;

  assign stat_cnt  = rdata[RXCNT_LSB +: RX_CNT_W];
  assign req_wdata = {{(APB_DW-8){1'b0}}, tx_data_i};

`ifdef UART_APB_SEQ_POLL_EN
  localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  logic [POLL_W-1:0] poll_cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      poll_cnt <= '0;
    end else if (state == IDLE && !poll_hit) begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end else begin
      poll_cnt <= '0;
    end
  end

  assign poll_hit = (state == IDLE) && (poll_cnt == POLL_W'(POLL_CYCLES - 1));
`else
  assign poll_hit = 1'b0;
`endif

  // The next transfer is decoded one cycle ahead so the engine's SETUP
  // cycle coincides with the FSM entering the matching *_S state.
  always_comb begin
    go_st    = 1'b0;
    go_rd    = 1'b0;
    go_tx    = 1'b0;
    req_addr = STAT_ADDR;
    case (state)
      IDLE: begin
        go_st = uart_int_i | (tx_valid_i & tx_full_q) | poll_hit;
        go_tx = tx_valid_i & ~tx_full_q & ~go_st;
      end
      ST_A: go_rd = done && (stat_cnt != '0);
      PUSH: begin
        if (rx_ready_i) begin
          go_rd = (rx_remain != '0);
          go_st = (rx_remain == '0);
        end
      end
      TX_A: go_st = 1'b1;
      default: ;
    endcase
    if (go_rd) begin
      req_addr = RXD_ADDR;
    end else if (go_tx) begin
      req_addr = TXD_ADDR;
    end
  end

  assign req = go_st | go_rd | go_tx;

  uart_apb_seq_master u_master (
    .clk     (clk),
    .rst_    (rst_),
    .req     (req),
    .addr    (req_addr),
    .wr      (go_tx),
    .wdata   (req_wdata),
    .prdata  (prdata_i),
    .done    (done),
    .rdata   (rdata),
    .paddr   (paddr_o),
    .pwdata  (pwdata_o),
    .psel    (psel_o),
    .penable (penable_o),
    .pwrite  (pwrite_o)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      rx_remain  <= '0;
      tx_full_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go_st) begin
            state <= ST_S;
          end else if (go_tx) begin
            state <= TX_S;
          end
        end
        ST_S: state <= ST_A;
        ST_A: begin
          rx_remain <= stat_cnt;
          tx_full_q <= rdata[TXFULL_BIT];
          state     <= go_rd ? RD_S : IDLE;
        end
        RD_S: state <= RD_A;
        RD_A: begin
          rx_data_q  <= rdata[7:0];
          rx_valid_q <= 1'b1;
          rx_remain  <= rx_remain - RX_CNT_W'(1);
          state      <= PUSH;
        end
        PUSH: begin
          if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
            state      <= go_rd ? RD_S : ST_S;
          end
        end
        TX_S: begin
          tx_ready_q <= 1'b1;
          state      <= TX_A;
        end
        TX_A: begin
          tx_full_q <= 1'b1;
          state     <= ST_S;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = tx_ready_q;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Self-checking bench for uart_apb_sequencer.
module tb_uart_apb_sequencer;

  localparam logic [31:0] A_TXD  = 32'h0000_0000;
  localparam logic [31:0] A_RXD  = 32'h0000_0004;
  localparam logic [31:0] A_STAT = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst_;
  logic        uart_int_i;
  logic [31:0] prdata_i;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        busy_o;

  always #5 clk = ~clk;

  uart_apb_sequencer #(.POLL_CYCLES(16)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .uart_int_i (uart_int_i),
    .prdata_i   (prdata_i),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] rxq[$];
  logic [7:0] exp_rx[$];
  int         checks = 0;
  int         errors = 0;
  int         tx_pulses = 0;
  int         psel_cycles = 0;

  always @(negedge clk) begin
    if (rx_valid_o && rx_ready_i) rxq.push_back(rx_data_o);
    if (tx_ready_o) tx_pulses++;
    if (psel_o) psel_cycles++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] a, input logic w,
                              input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    v.addr  = a;
    v.wr    = w;
    v.wdata = wd;
    v.rdata = rd;
    vecs.push_back(v);
  endfunction

  task automatic do_txn(input vec_t v, input int idx);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      prdata_i = '0;
      n++;
      if (psel_o && !penable_o) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL setup_timeout[%0d]: no SETUP within %0d cycles, expected addr %0h", idx, n, v.addr);
      return;
    end
    uart_int_i = 1'b0;
    chk($sformatf("setup[%0d]", idx),
        128'({paddr_o, pwrite_o, (pwrite_o ? pwdata_o : 32'h0)}),
        128'({v.addr, v.wr, (v.wr ? v.wdata : 32'h0)}));
    @(negedge clk);
    chk($sformatf("access[%0d]", idx),
        128'({psel_o, penable_o, paddr_o, pwrite_o, tx_ready_o}),
        128'({1'b1, 1'b1, v.addr, v.wr, v.wr}));
    prdata_i = v.rdata;
    if (v.wr) begin
      @(posedge clk);
      #1 tx_valid_i = 1'b0;
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) do_txn(vecs[i], i);
    vecs.delete();
  endtask

  task automatic check_rx(input string name);
    chk({name, "_count"}, 128'(rxq.size()), 128'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i),
          128'((i < rxq.size()) ? {1'b0, rxq[i]} : 9'h100),
          128'({1'b0, exp_rx[i]}));
    end
    rxq.delete();
    exp_rx.delete();
  endtask

  task automatic check_idle(input string name);
    repeat (3) @(negedge clk);
    #1 chk(name, 128'({busy_o, psel_o, rx_valid_o}), 128'(0));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({paddr_o, pwdata_o, psel_o, penable_o, pwrite_o,
                 rx_data_o, rx_valid_o, tx_ready_o, busy_o});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int t0;
    int n;
    bit found;

    rst_       = 1'b0;
    uart_int_i = 1'b0;
    prdata_i   = '0;
    rx_ready_i = 1'b1;
    tx_data_i  = '0;
    tx_valid_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'(0));
    @(posedge clk);
    #1 rst_ = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("idle_after_reset", 128'({psel_cycles, busy_o}), 128'(0));

    // Three-byte RX drain
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0003);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00A1);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00A2);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00A3);
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0000);
    exp_rx = '{8'hA1, 8'hA2, 8'hA3};
    @(posedge clk);
    #1 uart_int_i = 1'b1;
    run_vecs();
    check_rx("rx3");
    check_idle("idle_rx3");

    // Downstream stall on the first byte
    @(posedge clk);
    #1 rx_ready_i = 1'b0;
    uart_int_i = 1'b1;
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0002);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00B1);
    run_vecs();
    @(negedge clk);
    p0 = psel_cycles;
    repeat (19) @(negedge clk);
    #1 chk("stall_no_bus", 128'(psel_cycles - p0), 128'(0));
    chk("stall_hold", 128'({busy_o, rx_valid_o, rx_data_o}), 128'({1'b1, 1'b1, 8'hB1}));
    @(posedge clk);
    #1 rx_ready_i = 1'b1;
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00B2);
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0100);
    run_vecs();
    exp_rx = '{8'hB1, 8'hB2};
    check_rx("stall");
    check_idle("idle_stall");

    // TX with TX FIFO initially flagged full: status first, then write
    t0 = tx_pulses;
    @(posedge clk);
    #1 tx_data_i = 8'h55;
    tx_valid_i = 1'b1;
    add(A_STAT, 1'b0, 32'h0,           32'h0000_0000);
    add(A_TXD,  1'b1, 32'h0000_0055,   32'h0);
    add(A_STAT, 1'b0, 32'h0,           32'h0000_0100);
    run_vecs();
    check_idle("idle_tx");
    chk("tx55_pulses", 128'(tx_pulses - t0), 128'(1));

    // TX FIFO full for several status reads
    t0 = tx_pulses;
    @(posedge clk);
    #1 tx_data_i = 8'h66;
    tx_valid_i = 1'b1;
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0100);
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0100);
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0100);
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0000);
    add(A_TXD,  1'b1, 32'h0000_0066, 32'h0);
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0000);
    run_vecs();
    check_idle("idle_txfull");
    chk("tx66_pulses", 128'(tx_pulses - t0), 128'(1));

    // Interrupt and pending TX together: status, RX drain, then TX
    t0 = tx_pulses;
    @(posedge clk);
    #1 uart_int_i = 1'b1;
    tx_data_i  = 8'h77;
    tx_valid_i = 1'b1;
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0001);
    add(A_RXD,  1'b0, 32'h0,         32'h0000_00E1);
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0000);
    add(A_TXD,  1'b1, 32'h0000_0077, 32'h0);
    add(A_STAT, 1'b0, 32'h0,         32'h0000_0000);
    run_vecs();
    exp_rx = '{8'hE1};
    check_rx("both");
    chk("tx77_pulses", 128'(tx_pulses - t0), 128'(1));
    check_idle("idle_both");

    // Count of 16 drains all 16 bytes
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0010);
    for (int i = 0; i < 16; i++) begin
      add(A_RXD, 1'b0, 32'h0, 32'(8'hC0 + i));
      exp_rx.push_back(8'(8'hC0 + i));
    end
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0000);
    @(posedge clk);
    #1 uart_int_i = 1'b1;
    run_vecs();
    check_rx("rx16");
    check_idle("idle_rx16");

    // Asynchronous reset during an RXD ACCESS cycle
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0003);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_005A);
    @(posedge clk);
    #1 uart_int_i = 1'b1;
    run_vecs();
    #2 rst_ = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    chk("reset_held_outputs", all_outs(), 128'(0));
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0002);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00D1);
    add(A_RXD,  1'b0, 32'h0, 32'h0000_00D2);
    add(A_STAT, 1'b0, 32'h0, 32'h0000_0000);
    @(posedge clk);
    #1 uart_int_i = 1'b1;
    run_vecs();
    exp_rx = '{8'hD1, 8'hD2};
    check_rx("after_reset");
    check_idle("idle_after_reset_rx");

`ifdef UART_APB_SEQ_POLL_EN
    // Poll period: 16 idle cycles plus SETUP and ACCESS
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (psel_o && !penable_o) found = 1'b1;
    end
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (psel_o && !penable_o) found = 1'b1;
    end
    chk("poll_period", 128'(n), 128'(18));
`else
    found = 1'b0;
    n = 0;
    p0 = psel_cycles;
    repeat (60) @(negedge clk);
    #1 chk("no_poll_traffic", 128'(psel_cycles - p0), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
